// File: rtl/insn_queue_pkg.sv
// Shared types and constants for the instruction queue: instruction word,
// decoded-field positions and pointer/count width helpers.
package insn_queue_pkg;

  localparam int unsigned INSN_WIDTH = 99;

  // Decoded-instruction fields
  localparam int unsigned BR_FLAG_BIT = 9;
  localparam int unsigned BR_TGT_LSB  = 10;
  localparam int unsigned BR_TGT_MSB  = 41;

  typedef logic [INSN_WIDTH-1:0] insn_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/insn_queue_if.sv
// Aligner-side push group and issue-side read/pop signals of the instruction queue.
interface insn_queue_if #(
  parameter int unsigned DEPTH = 16
);
  import insn_queue_pkg::*;

  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic             i_Flush;
  logic [3:0]       i_valid;
  insn_t            i_isn1;
  insn_t            i_isn2;
  insn_t            i_isn3;
  insn_t            i_isn4;
  logic             o_Stall;
  logic [1:0]       i_pop;
  logic [1:0]       o_out_valid;
  insn_t            o_isn_a;
  insn_t            o_isn_b;
  logic [CNT_W-1:0] o_count;
  logic             o_empty;

  modport master (
    output i_Flush, i_valid, i_isn1, i_isn2, i_isn3, i_isn4, i_pop,
    input  o_Stall, o_out_valid, o_isn_a, o_isn_b, o_count, o_empty
  );

  modport slave (
    input  i_Flush, i_valid, i_isn1, i_isn2, i_isn3, i_isn4, i_pop,
    output o_Stall, o_out_valid, o_isn_a, o_isn_b, o_count, o_empty
  );

endinterface

// File: rtl/insn_compact.sv
// Packs the valid slots of a four-wide fetch group into the low slots, keeping
// program order, and reports how many were valid.
module insn_compact
  import insn_queue_pkg::*;
(
  input  logic [3:0] valid_i,
  input  insn_t      isn_i [4],
  output insn_t      slot_o [4],
  output logic [2:0] push_n_o
);

  always_comb begin
    logic [2:0] idx;
    for (int k = 0; k < 4; k++) begin
      slot_o[k] = '0;
    end
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (valid_i[i]) begin
        slot_o[idx[1:0]] = isn_i[i];
        idx = idx + 3'd1;
      end
    end
    push_n_o = idx;
  end

endmodule

// File: rtl/insn_queue.sv
// Four-in, two-out circular instruction queue between the aligner and issue.
// Stalls the front end whenever a full group might not fit.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input logic         i_Clk,
  input logic         i_Reset,
  insn_queue_if.slave q_if
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  insn_t            mem_q [DEPTH];

  insn_t            isn_in [4];
  insn_t            slot [4];
  logic [2:0]       push_n;
  logic             stall;
  logic             push_en;
  logic [1:0]       pop_req;
  logic [CNT_W-1:0] pop_n;
  logic [CNT_W-1:0] push_cnt;
  logic [1:0]       out_valid;

  assign isn_in[0] = q_if.i_isn1;
  assign isn_in[1] = q_if.i_isn2;
  assign isn_in[2] = q_if.i_isn3;
  assign isn_in[3] = q_if.i_isn4;

  insn_compact u_compact (
    .valid_i  (q_if.i_valid),
    .isn_i    (isn_in),
    .slot_o   (slot),
    .push_n_o (push_n)
  );

  // Stall depends on registered occupancy only, so i_pop never reaches o_Stall.
  assign stall    = count_q > CNT_W'(DEPTH - 4);
  assign push_en  = !stall && (q_if.i_valid != 4'b0000) && !q_if.i_Flush;
  assign pop_req  = (q_if.i_pop == 2'd3) ? 2'd2 : q_if.i_pop;
  assign pop_n    = (CNT_W'(pop_req) > count_q) ? count_q : CNT_W'(pop_req);
  assign push_cnt = push_en ? CNT_W'(push_n) : '0;

  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_cnt);
    count_d = count_q + push_cnt - pop_n;
    if (q_if.i_Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; unread entries are masked at the outputs.
  always_ff @(posedge i_Clk) begin
    if (push_en) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < push_n) begin
          mem_q[tail_q + PTR_W'(k)] <= slot[k];
        end
      end
    end
  end

  assign out_valid        = {count_q >= CNT_W'(2), count_q != '0};
  assign q_if.o_out_valid = out_valid;
  assign q_if.o_isn_a     = out_valid[0] ? mem_q[head_q] : '0;
  assign q_if.o_isn_b     = out_valid[1] ? mem_q[head_q + PTR_W'(1)] : '0;
  assign q_if.o_Stall     = stall;
  assign q_if.o_count     = count_q;
  assign q_if.o_empty     = (count_q == '0);

endmodule
